// File: rtl/spell_matcher.sv
// spell_matcher: tracks wand hits over a latched grid pattern and reports pass/fail per attempt
module spell_matcher #(
  parameter int TIMEOUT_CYCLES = 50000000,
  parameter int STRAY_MAX = 3,
  parameter int TW = 26
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        start,
  input  logic        abort,
  input  logic [15:0] trace,
  input  logic [15:0] ir_in,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [15:0] coverage,
  output logic [4:0]  progress,
  output logic [3:0]  strays
);
  typedef enum logic [1:0] {IDLE, ARM, TRACE, RESULT} state_t;
  state_t state;
  logic [15:0] pat_q, ir_prev, cov_next;
  logic [TW-1:0] timer;
  logic [3:0] strays_next;
  logic [4:0] pop;
  logic stray, complete, over, tmo;
  always_comb begin
    cov_next = coverage | (ir_in & pat_q);
    stray = |(ir_in & ~pat_q & ~ir_prev);
    strays_next = (stray && strays != 4'hf) ? strays + 4'd1 : strays;
    complete = (cov_next & pat_q) == pat_q;
    over = int'(strays_next) > STRAY_MAX;
    tmo = timer == TW'(TIMEOUT_CYCLES - 1);
    pop = '0;
    for (int i = 0; i < 16; i++) pop = pop + 5'(cov_next[i]);
  end
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state <= IDLE;
      busy <= 1'b0;
      done <= 1'b0;
      pass <= 1'b0;
      coverage <= '0;
      progress <= '0;
      strays <= '0;
      timer <= '0;
      pat_q <= '0;
      ir_prev <= '0;
    end else begin
      ir_prev <= ir_in;
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          pat_q <= trace;
          coverage <= '0;
          progress <= '0;
          strays <= '0;
          timer <= '0;
          pass <= 1'b0;
          state <= (trace == '0) ? RESULT : ARM;
          done <= trace == '0;
          busy <= trace != '0;
        end
        ARM: begin
          timer <= timer + 1'b1;
          if (abort) begin
            state <= IDLE;
            busy <= 1'b0;
          end else if (tmo) begin
            state <= RESULT;
            busy <= 1'b0;
            done <= 1'b1;
          end else if (ir_in == '0) state <= TRACE;
        end
        TRACE: begin
          timer <= timer + 1'b1;
          if (abort) begin
            state <= IDLE;
            busy <= 1'b0;
          end else begin
            coverage <= cov_next;
            progress <= pop;
            strays <= strays_next;
            // completion wins over both failure causes on the same cycle
            if (complete || over || tmo) begin
              state <= RESULT;
              busy <= 1'b0;
              done <= 1'b1;
              pass <= complete;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_spell_matcher.sv
// tb_spell_matcher: directed and random attempts checked against a cycle-indexed reference of the matching rules
module tb_spell_matcher;
  localparam int TO = 100;
  logic clk = 1'b0, resetn = 1'b0, start = 1'b0, abort = 1'b0;
  logic [15:0] trace = '0, ir_in = '0;
  logic busy, done, pass;
  logic [15:0] coverage;
  logic [4:0] progress;
  logic [3:0] strays;
  int n_cmp = 0, n_bad = 0;
  logic [15:0] seq[$];
  int e_cyc;
  logic e_pass;
  logic [15:0] e_cov;
  logic [3:0] e_st;

  always #5 clk = ~clk;

  spell_matcher #(.TIMEOUT_CYCLES(TO), .STRAY_MAX(3), .TW(8)) dut (
    .clk(clk), .resetn(resetn), .start(start), .abort(abort), .trace(trace), .ir_in(ir_in),
    .busy(busy), .done(done), .pass(pass), .coverage(coverage), .progress(progress), .strays(strays)
  );

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // seq[0] is the wand vector during the start cycle, seq[c] the vector c cycles later
  task automatic model(input logic [15:0] pat);
    logic [15:0] prev, cov, v;
    int st;
    bit tr;
    e_pass = 0; e_cov = '0; e_st = '0; e_cyc = 0;
    if (pat == '0) return;
    prev = seq[0]; cov = '0; st = 0; tr = 0;
    for (int c = 1; c <= TO; c++) begin
      v = (c < seq.size()) ? seq[c] : 16'h0;
      if (tr) begin
        cov |= v & pat;
        if ((v & ~pat & ~prev) != 16'h0 && st < 15) st++;
        e_cov = cov; e_st = 4'(st);
        if (cov == pat) begin e_pass = 1; e_cyc = c; return; end
        if (st > 3) begin e_cyc = c; return; end
      end else if (v == 16'h0) tr = 1;
      if (c == TO) begin e_cyc = c; return; end
      prev = v;
    end
  endtask

  task automatic run(input string name, input logic [15:0] pat, input int poke);
    logic [2:0] want;
    model(pat);
    start = 1'b1; trace = pat; ir_in = seq[0]; abort = 1'b0;
    for (int c = 0; c <= e_cyc; c++) begin
      step();
      want = {c == e_cyc, c < e_cyc, c == e_cyc ? e_pass : 1'b0};
      n_cmp++;
      if ({done, busy, pass} !== want) begin
        n_bad++;
        $display("FAIL %s ctrl: done/busy/pass=%b want %b at cycle %0d", name, {done, busy, pass}, want, c);
      end
      if (c == e_cyc) begin
        n_cmp++;
        if ({coverage, progress, strays} !== {e_cov, 5'($countones(e_cov)), e_st}) begin
          n_bad++;
          $display("FAIL %s result: cov=%h prog=%0d strays=%0d want cov=%h prog=%0d strays=%0d",
                   name, coverage, progress, strays, e_cov, $countones(e_cov), e_st);
        end
      end
      start = (c + 1 == poke);
      trace = start ? ~pat : pat;
      ir_in = (c + 1 < seq.size()) ? seq[c + 1] : 16'h0;
    end
    start = 1'b0; ir_in = '0;
    step();
    n_cmp++;
    if ({done, busy, pass, coverage, strays} !== {2'b00, e_pass, e_cov, e_st}) begin
      n_bad++;
      $display("FAIL %s idle: done=%b busy=%b pass=%b cov=%h strays=%0d want 0 0 %b %h %0d",
               name, done, busy, pass, coverage, strays, e_pass, e_cov, e_st);
    end
  endtask

  task automatic test_reset;
    resetn = 1'b0;
    repeat (3) step();
    n_cmp++;
    if ({busy, done, pass, coverage, progress, strays} !== 28'h0) begin
      n_bad++;
      $display("FAIL reset: outputs=%h want 0", {busy, done, pass, coverage, progress, strays});
    end
    resetn = 1'b1;
    step();
  endtask

  task automatic test_directed;
    seq = {16'h0, 16'h0, 16'h1, 16'h2, 16'h4, 16'h8};
    run("in_order", 16'h000F, -1);
    seq = {16'h0, 16'h0, 16'h8000, 16'h1, 16'h1, 16'h20, 16'h400};
    run("out_of_order", 16'h8421, -1);
    seq = {16'h0, 16'h0, 16'h100, 16'h0, 16'h100, 16'h0, 16'h100, 16'h0, 16'h100, 16'h1};
    run("too_many_strays", 16'h0003, -1);
    seq = {16'h0, 16'h0, 16'h1};
    run("timeout", 16'h0011, -1);
    seq = {16'h0, 16'h0, 16'h1, 16'h100, 16'h0, 16'h100, 16'h0, 16'h100, 16'h0, 16'h102};
    run("simultaneous", 16'h0003, -1);
    seq = {16'h5, 16'h5, 16'h5, 16'h5, 16'h0, 16'h4, 16'h1};
    run("arm_wait", 16'h0005, -1);
    seq = {16'h0};
    run("empty_trace", 16'h0000, -1);
    seq = {16'h0, 16'h0, 16'h1, 16'h0, 16'h0, 16'h2};
    run("start_ignored", 16'h0003, 3);
  endtask

  task automatic test_abort;
    start = 1'b1; trace = 16'h0003; ir_in = '0;
    step();
    start = 1'b0;
    step();
    ir_in = 16'h1;
    step();
    ir_in = 16'h100;
    step();
    ir_in = 16'h2; abort = 1'b1;
    step();
    abort = 1'b0; ir_in = '0;
    n_cmp++;
    if ({done, busy, pass, coverage, strays} !== {3'b000, 16'h0001, 4'd1}) begin
      n_bad++;
      $display("FAIL abort: done=%b busy=%b pass=%b cov=%h strays=%0d want 0 0 0 0001 1",
               done, busy, pass, coverage, strays);
    end
    step();
    n_cmp++;
    if ({done, busy} !== 2'b00) begin
      n_bad++;
      $display("FAIL abort_after: done=%b busy=%b want 0 0", done, busy);
    end
  endtask

  task automatic test_reset_mid_trace;
    start = 1'b1; trace = 16'h0003; ir_in = '0;
    step();
    start = 1'b0;
    step();
    ir_in = 16'h1;
    step();
    ir_in = 16'h100;
    step();
    ir_in = 16'h2; resetn = 1'b0;
    step();
    ir_in = '0;
    n_cmp++;
    if ({busy, done, pass, coverage, progress, strays} !== 28'h0) begin
      n_bad++;
      $display("FAIL reset_mid_trace: outputs=%h want 0", {busy, done, pass, coverage, progress, strays});
    end
    resetn = 1'b1;
    repeat (2) step();
    n_cmp++;
    if ({busy, done} !== 2'b00) begin
      n_bad++;
      $display("FAIL reset_after: busy=%b done=%b want 0 0", busy, done);
    end
  endtask

  task automatic test_random;
    logic [15:0] pat, v;
    for (int n = 0; n < 30; n++) begin
      pat = '0;
      if ($urandom_range(9) != 0)
        for (int k = 0; k <= int'($urandom_range(3)); k++) pat[$urandom_range(15)] = 1'b1;
      seq = {};
      seq.push_back($urandom_range(2) == 0 ? 16'($urandom) : 16'h0);
      for (int c = 1; c < 40; c++) begin
        case ($urandom_range(3))
          0: v = '0;
          1: v = pat & (16'h1 << $urandom_range(15));
          2: v = ~pat & (16'h1 << $urandom_range(15));
          default: v = 16'($urandom);
        endcase
        seq.push_back(v);
      end
      run($sformatf("random%0d", n), pat, $urandom_range(9) == 0 ? 4 : -1);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_abort();
    test_reset_mid_trace();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/spell_matcher.md
SPELL_MATCHER -- requirements
Module: spell_matcher

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 50000000, is the number of cycles allowed from start acceptance to completion (1 s at 50 MHz).
REQ-002 Parameter STRAY_MAX, default 3, is the number of stray-cell events tolerated; one more event causes failure.
REQ-003 Parameter TW, default 26, is the timer width and SHALL satisfy 2^TW > TIMEOUT_CYCLES.
REQ-004 clk  input  1  system clock; all logic is on the rising edge.
REQ-005 resetn  input  1  reset, synchronous and active-low.
REQ-006 start  input  1  one-cycle request to begin matching; honoured only in IDLE.
REQ-007 abort  input  1  cancels an attempt in progress.
REQ-008 trace  input  16  target spell pattern; bit n is grid cell n, row-major, cell 0 top-left.
REQ-009 ir_in  input  16  live wand-sensor hits per cell, the same vector that drives the grid display.
REQ-010 busy  output  1  high in ARM and TRACE.
REQ-011 done  output  1  one-cycle pulse when a result is valid.
REQ-012 pass  output  1  result of the last completed attempt; held until the next accepted start.
REQ-013 coverage  output  16  cells of the latched pattern hit so far.
REQ-014 progress  output  5  number of set bits in coverage, 0 to 16.
REQ-015 strays  output  4  saturating count of stray events.

Function
REQ-016 The FSM SHALL have four states: IDLE, ARM, TRACE and RESULT.
REQ-017 In IDLE, start=1 SHALL latch trace into pat_q, clear coverage, strays and timer, and clear pass.
REQ-018 On that same accepted start, the FSM SHALL go to RESULT with pass=0 if trace==0, and to ARM otherwise.
REQ-019 start SHALL be ignored in ARM, TRACE and RESULT, and SHALL not restart an attempt in progress.
REQ-020 ARM waits for the wand to be clear: the FSM SHALL enter TRACE on the first cycle with ir_in==0.
REQ-021 No coverage or stray updates SHALL occur in ARM.
REQ-022 The timer SHALL increment once per cycle in ARM and TRACE.
REQ-023 A cycle in ARM or TRACE with timer==TIMEOUT_CYCLES-1 SHALL go to RESULT with pass=0 (timeout), unless REQ-027 completion applies.
REQ-024 In TRACE, each cycle: coverage_next = coverage | (ir_in & pat_q).
REQ-025 Stray event: any bit of (ir_in & ~pat_q & ~ir_prev) set in TRACE, where ir_prev is ir_in registered one cycle earlier.
REQ-026 A stray event SHALL add exactly 1 to strays per cycle, however many bits rise, and strays SHALL saturate at 15.
REQ-027 Completion: (coverage_next & pat_q)==pat_q SHALL go to RESULT with pass=1.
REQ-028 Over-stray: strays_next > STRAY_MAX SHALL go to RESULT with pass=0.
REQ-029 Priority on the same cycle SHALL be completion, then over-stray, then timeout.
REQ-030 Pattern bits may be hit in any order, and re-hitting a covered cell SHALL have no effect.
REQ-031 RESULT SHALL last exactly one cycle, assert done=1, and return to IDLE.
REQ-032 coverage, progress and strays SHALL hold their values in RESULT and IDLE until the next accepted start.
REQ-033 abort=1 in ARM or TRACE SHALL go to IDLE with no done pulse, pass=0, and coverage and strays held.
REQ-034 abort SHALL take priority over every other transition, and SHALL be ignored in IDLE and RESULT.
REQ-035 progress SHALL be a registered popcount of coverage, updated in the same cycle as coverage.
REQ-036 ir_prev SHALL update every cycle in every state, so that a cell already held on entry to TRACE is not counted as a stray.

Reset
REQ-037 With resetn=0 at a clock edge, the block SHALL go to IDLE with busy=0, done=0, pass=0, coverage=0, progress=0, strays=0, timer=0, pat_q=0 and ir_prev=0.
REQ-038 Reset SHALL have priority over start and abort, and reset mid-attempt SHALL abandon it with no done pulse.

Verification
REQ-039 Pattern completed in order: trace=16'h000F, ir_in pulses cells 0,1,2,3 → done after the cell-3 cycle, pass=1, progress=4, strays=0.
REQ-040 Out of order with a repeat: trace=16'h8421, hits 15,0,0,5,10 → pass=1 on the cell-10 cycle.
REQ-041 Too many strays: trace=16'h0003, STRAY_MAX=3, four separate rising hits on cell 8 → pass=0 on the fourth hit with strays=4, and done fires once.
REQ-042 Timeout: TIMEOUT_CYCLES=100, trace=16'h0011, only cell 0 hit → done and pass=0 on cycle 100 after start, coverage=16'h0001.
REQ-043 Simultaneous events: the final pattern cell and a stray that crosses the limit arrive in the same cycle → pass=1.
REQ-044 Control corner cases:
- ir_in nonzero at start stays in ARM until it clears.
- abort in TRACE gives no done pulse and busy=0.
- resetn=0 mid-TRACE clears all outputs next cycle.
- trace=0 gives done one cycle after start with pass=0.
